pwm_motor_array: RTL and testbench

- Parametrised N-channel sign/magnitude PWM H-bridge driver.
- Successor to the fixed two-motor controller. Uses a prescaler clock-enable instead of a divided clock.
- Double-buffers commands so they change only on PWM period boundaries.
- Inserts a coast dead-time whenever a channel reverses direction.
- Sits between the SPI command registers and the H-bridge pins (enable, a-pair per channel).

---
 rtl/pwm_motor_array.sv | 200 ++++++++++++++++++++
 tb/tb_pwm_motor_array.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_motor_array.sv
// N-channel sign/magnitude PWM H-bridge driver with period-aligned command
// double-buffering and coast dead-time on direction reversal.
//
// state | meaning
// IDLE  | no command committed since reset; bridge coasts
// RUN   | driving active sign/magnitude
// DEAD  | reversal in progress; bridge coasts until dead_cnt expires
module pwm_motor_array #(
  parameter int CHANNELS = 2,
  parameter int MAG_W    = 7,
  parameter int PRESCALE = 104,
  parameter int DEADTIME = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [CHANNELS-1:0]       cmd_sign,
  input  logic [CHANNELS*MAG_W-1:0] cmd_mag,
  output logic [CHANNELS-1:0]       enable,
  output logic [CHANNELS-1:0]       dir_a,
  output logic [CHANNELS-1:0]       dir_b,
  output logic [CHANNELS-1:0]       dead,
  output logic                      period_start
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DC_W  = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [MAG_W-1:0] CNT_LAST  = MAG_W'((1 << MAG_W) - 2);
  localparam logic [DC_W-1:0]  DEAD_INIT = DC_W'(DEADTIME);
  localparam bit               HAS_DEAD  = (DEADTIME > 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [MAG_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             period_start_q, period_start_d;
  logic             pending_q, pending_d;

  logic [CHANNELS-1:0]            stg_sign_q, stg_sign_d;
  logic [CHANNELS-1:0][MAG_W-1:0] stg_mag_q, stg_mag_d;

  state_t                         state_q [CHANNELS];
  state_t                         state_d [CHANNELS];
  logic [CHANNELS-1:0]            act_sign_q, act_sign_d;
  logic [CHANNELS-1:0][MAG_W-1:0] act_mag_q, act_mag_d;
  logic [CHANNELS-1:0]            tgt_sign_q, tgt_sign_d;
  logic [CHANNELS-1:0][MAG_W-1:0] tgt_mag_q, tgt_mag_d;
  logic [CHANNELS-1:0][DC_W-1:0]  dead_cnt_q, dead_cnt_d;

  logic [CHANNELS-1:0] enable_q, enable_d;
  logic [CHANNELS-1:0] dir_a_q, dir_a_d;
  logic [CHANNELS-1:0] dir_b_q, dir_b_d;
  logic [CHANNELS-1:0] dead_q, dead_d;

  logic             tick;
  logic             boundary;
  logic             commit;
  logic             nxt_sign;
  logic [MAG_W-1:0] nxt_mag;

  always_comb begin
    tick     = (pre_cnt_q == PRE_LAST);
    boundary = tick && (pwm_cnt_q == CNT_LAST);
    commit   = boundary && pending_q;

    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    pwm_cnt_d = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = boundary ? '0 : pwm_cnt_q + MAG_W'(1);
    end
    period_start_d = boundary;

    // A load on the boundary clk restages for the next period while the
    // previously staged command (if any) still commits now.
    stg_sign_d = stg_sign_q;
    stg_mag_d  = stg_mag_q;
    pending_d  = pending_q;
    if (boundary) begin
      pending_d = 1'b0;
    end
    if (load) begin
      stg_sign_d = cmd_sign;
      for (int i = 0; i < CHANNELS; i++) begin
        stg_mag_d[i] = cmd_mag[i*MAG_W +: MAG_W];
      end
      pending_d = 1'b1;
    end

    state_d    = state_q;
    act_sign_d = act_sign_q;
    act_mag_d  = act_mag_q;
    tgt_sign_d = tgt_sign_q;
    tgt_mag_d  = tgt_mag_q;
    dead_cnt_d = dead_cnt_q;
    nxt_sign   = 1'b0;
    nxt_mag    = '0;

    for (int i = 0; i < CHANNELS; i++) begin
      if (boundary) begin
        case (state_q[i])
          ST_IDLE: begin
            if (commit) begin
              state_d[i]    = ST_RUN;
              act_sign_d[i] = stg_sign_q[i];
              act_mag_d[i]  = stg_mag_q[i];
            end
          end
          ST_RUN: begin
            if (commit) begin
              if (HAS_DEAD && (stg_sign_q[i] != act_sign_q[i])) begin
                state_d[i]    = ST_DEAD;
                tgt_sign_d[i] = stg_sign_q[i];
                tgt_mag_d[i]  = stg_mag_q[i];
                dead_cnt_d[i] = DEAD_INIT;
              end else begin
                act_sign_d[i] = stg_sign_q[i];
                act_mag_d[i]  = stg_mag_q[i];
              end
            end
          end
          ST_DEAD: begin
            // A commit landing on the exit boundary is honoured immediately.
            nxt_sign      = commit ? stg_sign_q[i] : tgt_sign_q[i];
            nxt_mag       = commit ? stg_mag_q[i]  : tgt_mag_q[i];
            tgt_sign_d[i] = nxt_sign;
            tgt_mag_d[i]  = nxt_mag;
            if (dead_cnt_q[i] <= DC_W'(1)) begin
              dead_cnt_d[i] = '0;
              state_d[i]    = ST_RUN;
              act_sign_d[i] = nxt_sign;
              act_mag_d[i]  = nxt_mag;
            end else begin
              dead_cnt_d[i] = dead_cnt_q[i] - DC_W'(1);
            end
          end
          default: state_d[i] = ST_IDLE;
        endcase
      end

      enable_d[i] = (state_q[i] == ST_RUN) && (pwm_cnt_q < act_mag_q[i]);
      dir_a_d[i]  = (state_q[i] == ST_RUN) && !act_sign_q[i];
      dir_b_d[i]  = (state_q[i] == ST_RUN) && act_sign_q[i];
      dead_d[i]   = (state_q[i] == ST_DEAD);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      period_start_q <= 1'b0;
      pending_q      <= 1'b0;
      stg_sign_q     <= '0;
      stg_mag_q      <= '0;
      act_sign_q     <= '0;
      act_mag_q      <= '0;
      tgt_sign_q     <= '0;
      tgt_mag_q      <= '0;
      dead_cnt_q     <= '0;
      enable_q       <= '0;
      dir_a_q        <= '0;
      dir_b_q        <= '0;
      dead_q         <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_IDLE;
      end
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= period_start_d;
      pending_q      <= pending_d;
      stg_sign_q     <= stg_sign_d;
      stg_mag_q      <= stg_mag_d;
      act_sign_q     <= act_sign_d;
      act_mag_q      <= act_mag_d;
      tgt_sign_q     <= tgt_sign_d;
      tgt_mag_q      <= tgt_mag_d;
      dead_cnt_q     <= dead_cnt_d;
      enable_q       <= enable_d;
      dir_a_q        <= dir_a_d;
      dir_b_q        <= dir_b_d;
      dead_q         <= dead_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign enable       = enable_q;
  assign dir_a        = dir_a_q;
  assign dir_b        = dir_b_q;
  assign dead         = dead_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_motor_array.sv
// Bench for pwm_motor_array: period-granular reference model of commands,
// dead-time and duty, compared sample by sample against the outputs.
module tb_pwm_motor_array;
  localparam int CH  = 2;
  localparam int MW  = 7;
  localparam int PS  = 1;
  localparam int DT  = 2;
  localparam int PER = (1 << MW) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load = 1'b0;
  logic [CH-1:0]     cmd_sign = '0;
  logic [CH*MW-1:0]  cmd_mag = '0;
  logic [CH-1:0]     enable, dir_a, dir_b, dead;
  logic              period_start;

  int checks = 0;
  int errors = 0;

  pwm_motor_array #(.CHANNELS(CH), .MAG_W(MW), .PRESCALE(PS), .DEADTIME(DT)) dut (
    .clk(clk), .reset(reset), .load(load), .cmd_sign(cmd_sign), .cmd_mag(cmd_mag),
    .enable(enable), .dir_a(dir_a), .dir_b(dir_b), .dead(dead),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 run, 2 dead. Commands waiting for the end of the
  // current period live in p_now; a load on the boundary clk goes to p_next.
  int              m_mode [CH];
  bit              m_sign [CH];
  int              m_mag  [CH];
  bit              m_tsign[CH];
  int              m_tmag [CH];
  int              m_dleft[CH];
  bit              p_now_v, p_next_v;
  logic [CH-1:0]   p_now_s, p_next_s;
  logic [CH*MW-1:0] p_now_m, p_next_m;

  function automatic logic [CH*MW-1:0] mags(input int a, input int b);
    logic [MW-1:0] ma, mb;
    ma = MW'(a);
    mb = MW'(b);
    return {mb, ma};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_mode[c] = 0; m_sign[c] = 0; m_mag[c] = 0;
      m_tsign[c] = 0; m_tmag[c] = 0; m_dleft[c] = 0;
    end
    p_now_v = 0; p_next_v = 0; p_now_s = '0; p_next_s = '0; p_now_m = '0; p_next_m = '0;
  endtask

  task automatic model_boundary();
    bit ns;
    int nm;
    for (int c = 0; c < CH; c++) begin
      ns = p_now_s[c];
      nm = int'(p_now_m[c*MW +: MW]);
      if (m_mode[c] == 2) begin
        m_dleft[c]--;
        if (p_now_v) begin m_tsign[c] = ns; m_tmag[c] = nm; end
        if (m_dleft[c] == 0) begin
          m_mode[c] = 1; m_sign[c] = m_tsign[c]; m_mag[c] = m_tmag[c];
        end
      end else if (p_now_v) begin
        if (m_mode[c] == 1 && ns != m_sign[c] && DT > 0) begin
          m_mode[c] = 2; m_tsign[c] = ns; m_tmag[c] = nm; m_dleft[c] = DT;
        end else begin
          m_mode[c] = 1; m_sign[c] = ns; m_mag[c] = nm;
        end
      end
    end
    p_now_v = p_next_v; p_now_s = p_next_s; p_now_m = p_next_m;
    p_next_v = 0;
  endtask

  task automatic drive_load(input logic [CH-1:0] s, input logic [CH*MW-1:0] m, input bit defer);
    load = 1'b1;
    cmd_sign = s;
    cmd_mag = m;
    if (defer) begin
      p_next_v = 1; p_next_s = s; p_next_m = m;
    end else begin
      p_now_v = 1; p_now_s = s; p_now_m = m;
    end
  endtask

  task automatic sync_period(output int n);
    n = 0;
    for (int i = 1; i <= 3 * PER; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      errors++;
      $display("FAIL sync_period: period_start not seen within %0d clk", 3 * PER);
    end
  endtask

  // Samples one full period of outputs (k=1..PER after a period_start clk),
  // optionally pulsing load at sample ld_k, then advances the model.
  task automatic measure_period(input string tag, input int ld_k,
                                input logic [CH-1:0] ls, input logic [CH*MW-1:0] lm);
    int en_mis[CH], en_hi[CH], exp_hi[CH], dir_mis[CH], dead_mis[CH];
    int ps_mis;
    logic exp_en, exp_a, exp_b, exp_d;
    ps_mis = 0;
    for (int c = 0; c < CH; c++) begin
      en_mis[c] = 0; en_hi[c] = 0; exp_hi[c] = 0; dir_mis[c] = 0; dead_mis[c] = 0;
    end
    for (int k = 1; k <= PER; k++) begin
      @(negedge clk);
      load = 1'b0;
      for (int c = 0; c < CH; c++) begin
        exp_en = (m_mode[c] == 1) && (k - 1 < m_mag[c]);
        exp_a  = (m_mode[c] == 1) && !m_sign[c];
        exp_b  = (m_mode[c] == 1) && m_sign[c];
        exp_d  = (m_mode[c] == 2);
        if (exp_en) exp_hi[c]++;
        if (enable[c] === 1'b1) en_hi[c]++;
        if (enable[c] !== exp_en) en_mis[c]++;
        if ({dir_a[c], dir_b[c]} !== {exp_a, exp_b}) dir_mis[c]++;
        if (dead[c] !== exp_d) dead_mis[c]++;
      end
      if (period_start !== (k == PER)) ps_mis++;
      if (k == ld_k) drive_load(ls, lm, k == PER - 1);
    end
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (en_mis[c] !== 0) begin
        errors++;
        $display("FAIL %s ch%0d enable: %0d high (%0d misplaced), expected %0d high from period start",
                 tag, c, en_hi[c], en_mis[c], exp_hi[c]);
      end
      checks++;
      if (dir_mis[c] !== 0) begin
        errors++;
        $display("FAIL %s ch%0d dir: %0d wrong samples, expected dir_a=%0b dir_b=%0b",
                 tag, c, dir_mis[c], (m_mode[c] == 1) && !m_sign[c], (m_mode[c] == 1) && m_sign[c]);
      end
      checks++;
      if (dead_mis[c] !== 0) begin
        errors++;
        $display("FAIL %s ch%0d dead: %0d wrong samples, expected %0b", tag, c, dead_mis[c], m_mode[c] == 2);
      end
    end
    checks++;
    if (ps_mis !== 0) begin
      errors++;
      $display("FAIL %s period_start: %0d wrong samples, expected one pulse every %0d clk", tag, ps_mis, PER);
    end
    model_boundary();
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({enable, dir_a, dir_b, dead, period_start} !== '0) begin
      errors++;
      $display("FAIL %s: en=%b a=%b b=%b dead=%b ps=%b, expected all 0",
               tag, enable, dir_a, dir_b, dead, period_start);
    end
  endtask

  task automatic release_and_sync(input string tag);
    int n;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    sync_period(n);
    checks++;
    if (n !== PER) begin
      errors++;
      $display("FAIL %s first period_start: at clk %0d, expected %0d", tag, n, PER);
    end
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_hold");
    release_and_sync("reset_release");
    for (int p = 0; p < 8; p++) measure_period("idle", -1, '0, '0);
  endtask

  task automatic test_duty();
    drive_load(2'b10, mags(25, 50), 0);
    measure_period("duty_pre", -1, '0, '0);
    measure_period("duty", -1, '0, '0);
    measure_period("duty", -1, '0, '0);
  endtask

  task automatic test_full_zero();
    drive_load(2'b10, mags(127, 50), 0);
    for (int p = 0; p < 3; p++) measure_period("full", -1, '0, '0);
    drive_load(2'b10, mags(0, 50), 0);
    for (int p = 0; p < 3; p++) measure_period("zero", -1, '0, '0);
  endtask

  task automatic test_reversal();
    drive_load(2'b10, mags(25, 50), 0);
    measure_period("rev_setup", -1, '0, '0);
    measure_period("rev_setup", -1, '0, '0);
    drive_load(2'b11, mags(25, 50), 0);
    for (int p = 0; p < 5; p++) measure_period("rev", -1, '0, '0);
    drive_load(2'b10, mags(25, 50), 0);
    measure_period("rev2_commit", -1, '0, '0);
    measure_period("rev2_dead1", 50, 2'b11, mags(90, 50));
    for (int p = 0; p < 3; p++) measure_period("rev2", -1, '0, '0);
  endtask

  task automatic test_back_to_back();
    drive_load(2'b10, mags(10, 50), 0);
    measure_period("b2b_load", 60, 2'b10, mags(90, 50));
    measure_period("b2b", -1, '0, '0);
    measure_period("bound_load", 126, 2'b10, mags(40, 50));
    measure_period("bound_wait", -1, '0, '0);
    measure_period("bound_apply", -1, '0, '0);
  endtask

  task automatic test_random();
    logic [CH-1:0]    s;
    logic [CH*MW-1:0] m;
    int k;
    for (int it = 0; it < 16; it++) begin
      s = CH'($urandom);
      m = (CH*MW)'($urandom);
      if (it % 5 == 1) m[MW-1:0] = '1;
      if (it % 7 == 2) m[2*MW-1:MW] = '0;
      k = $urandom_range(0, PER - 1);
      if (k == 0) begin
        drive_load(s, m, 0);
        measure_period("rand", -1, '0, '0);
      end else begin
        measure_period("rand", k, s, m);
      end
      measure_period("rand_follow", -1, '0, '0);
    end
  endtask

  task automatic test_reset_mid();
    drive_load(2'b11, mags(40, 50), 0);
    drive_load(2'b10, mags(40, 50), 0);
    measure_period("mid_setup", -1, '0, '0);
    drive_load(2'b11, mags(40, 50), 0);
    measure_period("mid_commit", -1, '0, '0);
    repeat (40) @(negedge clk);
    checks++;
    if (dead[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_dead_before_reset: dead0=%b, expected 1", dead[0]);
    end
    drive_load(2'b00, mags(70, 70), 0);
    @(negedge clk);
    load = 1'b0;
    #2 reset = 1'b0;
    #1 check_all_zero("reset_mid_dead");
    repeat (2) @(negedge clk);
    check_all_zero("reset_mid_dead_hold");
    release_and_sync("mid_dead_release");
    measure_period("after_reset", -1, '0, '0);
    measure_period("after_reset", -1, '0, '0);
    drive_load(2'b01, mags(60, 30), 0);
    measure_period("mid_run_setup", -1, '0, '0);
    measure_period("mid_run", -1, '0, '0);
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("reset_mid_run");
    release_and_sync("mid_run_release");
    measure_period("after_reset2", -1, '0, '0);
    measure_period("after_reset2", -1, '0, '0);
  endtask

  initial begin
    test_reset();
    test_duty();
    test_full_zero();
    test_reversal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
